// File: rtl/popcount_arbiter.sv
// Round-robin arbiter sharing one 8-bit bitCounter between two requesters.
// The granted word is streamed LSB byte first and the per-byte counts are summed.
module popcount_arbiter #(
    parameter int BYTES = 4,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [8*BYTES-1:0] req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [8*BYTES-1:0] req1_data,
    output logic               req1_ready,
    output logic [7:0]         bc_in,
    input  logic [3:0]         bc_out,
    output logic               res_valid,
    output logic [CNT_W-1:0]   res_data,
    output logic               res_id,
    input  logic               res_ready,
    output logic               busy
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic               id_q, id_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [8*BYTES-1:0] word_q, word_d;

    logic grant;
    logic hs0, hs1;

    // Requester 1 wins when alone, or when both ask and it holds priority.
    assign grant = req1_valid & (~req0_valid | prio_q);
    assign hs0   = ~reset & (state_q == IDLE) & req0_valid & ~grant;
    assign hs1   = ~reset & (state_q == IDLE) & req1_valid & grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            acc_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hs0 | hs1) state_d = COUNT;
            COUNT:   if (idx_q == LAST) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        id_d   = id_q;
        acc_d  = acc_q;
        idx_d  = idx_q;
        word_d = word_q;
        if (hs0 | hs1) begin
            word_d = hs1 ? req1_data : req0_data;
            id_d   = hs1;
            prio_d = ~hs1;
            acc_d  = '0;
            idx_d  = '0;
        end else if (state_q == COUNT) begin
            acc_d = acc_q + CNT_W'(bc_out);
            idx_d = idx_q + 1'b1;
        end
    end

    always_comb begin
        req0_ready = hs0;
        req1_ready = hs1;
        busy       = (state_q != IDLE);
        res_valid  = (state_q == DONE);
        res_data   = acc_q;
        res_id     = id_q;
        bc_in      = '0;
        if (state_q == COUNT) bc_in = word_q[{idx_q, 3'b000} +: 8];
    end

endmodule
